if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Instruction-fetch stage that sits directly downstream of the PC register in the single-cycle core's instr_fetch area.
- Takes the current fetch address and issues single-outstanding requests to instruction memory. Memory latency is variable.
- Buffers returned {pc, instr} pairs in a small FIFO for decode.
- Flush on any jump or branch redirect discards queued and in-flight instructions so no wrong-path instruction reaches decode.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
NOP_INSTR, 32'h00000013, instr value driven when instr_valid=0

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  reset
pc_addr  in  32  fetch address from PC stage
pc_valid  in  1  pc_addr is valid
pc_adv  out  1  address accepted this cycle; PC may advance
flush  in  1  redirect (OR of jmp_en/jmpr_en/jmpb_en)
imem_req  out  1  memory request
imem_addr  out  32  request address (= pc_addr)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  instruction word
instr_valid  out  1  FIFO head valid
instr  out  32  head instruction
instr_pc  out  32  head instruction address
instr_ready  in  1  decode consumes head

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous, active-high. Active-high, so no _n suffix.
- Reset (rst=1 at posedge): state=IDLE, count=0, rd/wr pointers=0, imem_req=0, pc_adv=0, instr_valid=0, instr=NOP_INSTR, instr_pc=0.
- Reset mid-transaction abandons the in-flight request. Instruction memory shares rst, so no stale rvalid follows.
- States:
  - IDLE: nothing outstanding.
  - WAIT: one request outstanding; response will be kept.
  - DROP: one request outstanding; response will be discarded.
- can_issue = !flush && (IDLE || (WAIT && imem_rvalid)) && (count + (state==WAIT)) < DEPTH. Uses registered count only; no pop term.
- imem_req = pc_valid && can_issue; imem_addr = pc_addr.
- fire = imem_req && imem_gnt; pc_adv = fire (combinational).
- Issued pc is held in a register until its response arrives.
- Transitions:
  - IDLE --fire--> WAIT.
  - WAIT + rvalid: push {held_pc, rdata}. Next state is WAIT if fire that cycle, else IDLE. Back-to-back throughput is 1 instr/cycle with 1-cycle memory.
  - WAIT + flush, no rvalid: -> DROP.
  - WAIT + flush + rvalid: data discarded -> IDLE.
  - DROP + rvalid: discard -> IDLE. Flush in DROP: stay DROP. No issue from DROP.
  - IDLE + flush: stay IDLE.
- FIFO:
  - pop = instr_valid && instr_ready.
  - Push and pop in the same cycle: count unchanged. Full push never occurs, guaranteed by can_issue.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.
  - instr_valid = count!=0. instr/instr_pc are combinational from the head entry; instr=NOP_INSTR when empty.
- Flush (same cycle, synchronous): count<=0, pointers<=0, any simultaneous push and pop ignored, pc_adv=0.
  - First post-flush request is issued the cycle after flush deasserts, from the redirected pc_addr.
- Misaligned pc_addr is not checked; bits [1:0] pass through.

Optional Feature:
- Macro IF_FETCH_BYPASS_EN.
- Defined: when count==0, state==WAIT, imem_rvalid=1 and no flush:
  - instr_valid=1, instr=imem_rdata, instr_pc=held_pc in the same cycle.
  - If instr_ready=1 the word is not pushed (zero-latency path); otherwise it is pushed normally.
- Undefined: every response enters the FIFO; minimum rvalid-to-instr_valid latency is 1 cycle.

Decomposition:
- Shared package if_pkg: NOP_INSTR constant, state encoding (IDLE=2'd0, WAIT=2'd1, DROP=2'd2), fetch-entry typedef {pc[31:0], instr[31:0]}.
- One natural sub-module: if_sync_fifo (DEPTH x 64-bit, push/pop/clear, count output).
- FSM, issue logic and bypass stay in the top.

Test Plan:
- Reset: rst=1 two cycles, pc_valid=1 -> imem_req=0, instr_valid=0, instr=32'h00000013; first req cycle after rst drops, imem_addr=0.
- Streaming: 1-cycle memory, gnt=1, instr_ready=1, pc 0,4,8,... -> after fill, one pop per cycle, instr_pc sequence 0,4,8,C, no gaps.
- Full: instr_ready=0, DEPTH=4 -> exactly 4 entries stored; no request while count+outstanding==4; with memory idle, count holds 4 and imem_req stays 0.
- Flush in flight: req pc=0x10 granted, flush next cycle, rvalid 3 cycles later with 0xDEADBEEF -> word never appears at instr; next request is pc=0x40 (redirect target).
- Simultaneous: state WAIT, flush and rvalid same cycle, count=2 -> count=0, state IDLE, no push.
- Bypass (macro on): empty FIFO, rvalid with rdata=0x00500093 at pc 0x8, instr_ready=1 -> instr_valid=1, instr=0x00500093, instr_pc=0x8 same cycle; count stays 0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package if_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/if_sync_fifo.sv
// DEPTH-entry FIFO of {pc, instr} pairs with synchronous clear; the head
// entry is read combinationally.
module if_sync_fifo
   import if_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  fetch_entry_t             wdata_i,
   output fetch_entry_t             rdata_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   fetch_entry_t   mem_q [DEPTH];
   logic [AW-1:0]  wr_q;
   logic [AW-1:0]  rd_q;
   logic [AW:0]    count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i)  rd_q <= rd_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !clear_i && !rst_i) mem_q[wr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_q];
   assign count_o = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch with one outstanding memory request and a decode FIFO.
// Define IF_FETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module if_fetch_queue #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_addr,
   input  logic        pc_valid,
   output logic        pc_adv,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   import if_pkg::*;

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   held_pc_q, held_pc_d;
   logic [CW-1:0] count;
   logic [CW:0]   occupancy;
   fetch_entry_t  head, push_entry;
   logic          can_issue, fire, resp_keep, bypass, push, pop;

   // An outstanding kept response reserves a slot; pops are ignored so the FIFO can never overflow.
   assign occupancy = {1'b0, count} + {{CW{1'b0}}, (state_q == S_WAIT)};
   assign can_issue = !rst && !flush
                    && ((state_q == S_IDLE) || ((state_q == S_WAIT) && imem_rvalid))
                    && (occupancy < (CW+1)'(DEPTH));

   assign imem_req  = pc_valid && can_issue;
   assign imem_addr = pc_addr;
   assign fire      = imem_req && imem_gnt;
   assign pc_adv    = fire;

   assign resp_keep  = (state_q == S_WAIT) && imem_rvalid && !flush;
   assign push_entry = '{pc: held_pc_q, instr: imem_rdata};
   assign pop        = (count != '0) && instr_ready;

`ifdef IF_FETCH_BYPASS_EN
   assign bypass = resp_keep && (count == '0);
   assign push   = resp_keep && !(bypass && instr_ready);
`else
   assign bypass = 1'b0;
   assign push   = resp_keep;
`endif

   always_comb begin
      instr_valid = 1'b0;
      instr       = NOP_INSTR;
      instr_pc    = '0;
      if (count != '0) begin
         instr_valid = 1'b1;
         instr       = head.instr;
         instr_pc    = head.pc;
      end else if (bypass) begin
         instr_valid = 1'b1;
         instr       = imem_rdata;
         instr_pc    = held_pc_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      held_pc_d = held_pc_q;
      if (fire) held_pc_d = pc_addr;
      case (state_q)
         S_IDLE:  if (fire) state_d = S_WAIT;
         S_WAIT: begin
            if (imem_rvalid)  state_d = fire ? S_WAIT : S_IDLE;
            else if (flush)   state_d = S_DROP;
         end
         S_DROP:  if (imem_rvalid) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         held_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         held_pc_q <= held_pc_d;
      end
   end

   if_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .clear_i (flush),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (push_entry),
      .rdata_o (head),
      .count_o (count)
   );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed cycle table, then randomized traffic
// checked against a queue-based reference model.
module tb_if_fetch_queue;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IF_FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [31:0] pc_addr;
   logic        pc_valid;
   logic        pc_adv;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   if_fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_addr     (pc_addr),
      .pc_valid    (pc_valid),
      .pc_adv      (pc_adv),
      .flush       (flush),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        rst, pv;
      logic [31:0] pa;
      logic        fl, gnt, rv;
      logic [31:0] rd;
      logic        rdy;
      logic        e_req, e_adv, e_val;
      logic [31:0] e_ins, e_pc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic pv, input logic [31:0] pa, input logic fl,
                      input logic gnt, input logic rv, input logic [31:0] rd, input logic rdy,
                      input logic e_req, input logic e_adv, input logic e_val,
                      input logic [31:0] e_ins, input logic [31:0] e_pc);
      vec_t v;
      v.rst = r; v.pv = pv; v.pa = pa; v.fl = fl; v.gnt = gnt; v.rv = rv; v.rd = rd;
      v.rdy = rdy; v.e_req = e_req; v.e_adv = e_adv; v.e_val = e_val;
      v.e_ins = e_ins; v.e_pc = e_pc;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic pv, input logic [31:0] pa, input logic fl,
                        input logic gnt, input logic rv, input logic [31:0] rd, input logic rdy);
      rst = r; pc_valid = pv; pc_addr = pa; flush = fl;
      imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd; instr_ready = rdy;
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        mq[$];
   bit          m_out, m_keep;
   logic [31:0] m_pc;
   logic        e_req, e_adv, e_val, e_byp;
   logic [31:0] e_ins, e_pc;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic model_eval();
      int unsigned cnt;
      int unsigned reserved;
      bit kept_resp;
      cnt       = mq.size();
      reserved  = (m_out && m_keep) ? 1 : 0;
      kept_resp = m_out && m_keep && imem_rvalid;
      e_req = pc_valid && !rst && !flush && (!m_out || kept_resp) && (cnt + reserved < DEPTH);
      e_adv = e_req && imem_gnt;
      e_byp = BYP && (cnt == 0) && kept_resp && !flush;
      if (cnt != 0) begin
         e_val = 1'b1; e_ins = mq[0].ins; e_pc = mq[0].pc;
      end else if (e_byp) begin
         e_val = 1'b1; e_ins = imem_rdata; e_pc = m_pc;
      end else begin
         e_val = 1'b0; e_ins = NOP; e_pc = 32'h0;
      end
   endtask

   task automatic model_update();
      ent_t e;
      if (rst) begin
         mq.delete(); m_out = 0; m_keep = 0;
      end else if (flush) begin
         mq.delete();
         if (m_out) begin
            if (imem_rvalid) m_out = 0;
            else             m_keep = 0;
         end
      end else begin
         if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
         if (m_out && imem_rvalid) begin
            if (m_keep && !(e_byp && instr_ready)) begin
               e.pc = m_pc; e.ins = imem_rdata;
               mq.push_back(e);
            end
            m_out = 0;
         end
         if (e_adv) begin
            m_out = 1; m_keep = 1; m_pc = pc_addr;
         end
      end
   endtask

   initial begin
      logic [31:0] pc;
      bit          pend;
      int unsigned lat;
      logic [31:0] pend_addr;

      drive(1, 1, 32'h0, 0, 1, 0, 32'h0, 1);
      @(posedge clk); #1;

      // rst pv pa fl gnt rv rd rdy | req adv val ins pc
      add(1, 1, 32'h00, 0, 1, 0, 32'h0,         1, 0, 0, 0, NOP,           32'h00);
      if (!BYP) begin
         add(0, 1, 32'h00, 0, 1, 0, 32'h0,         1, 1, 1, 0, NOP,           32'h00);
         add(0, 1, 32'h04, 0, 1, 1, 32'h1000_0000, 1, 1, 1, 0, NOP,           32'h00);
         add(0, 1, 32'h08, 0, 1, 1, 32'h1000_0004, 1, 1, 1, 1, 32'h1000_0000, 32'h00);
         add(0, 1, 32'h0C, 0, 1, 1, 32'h1000_0008, 1, 1, 1, 1, 32'h1000_0004, 32'h04);
         add(0, 1, 32'h10, 0, 1, 1, 32'h1000_000C, 1, 1, 1, 1, 32'h1000_0008, 32'h08);
         add(0, 1, 32'h40, 1, 1, 0, 32'h0,         1, 0, 0, 1, 32'h1000_000C, 32'h0C);
         add(0, 1, 32'h40, 0, 1, 0, 32'h0,         1, 0, 0, 0, NOP,           32'h00);
         add(0, 1, 32'h40, 0, 1, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, NOP,           32'h00);
         add(0, 1, 32'h40, 0, 1, 0, 32'h0,         1, 1, 1, 0, NOP,           32'h00);
         add(0, 1, 32'h44, 0, 1, 1, 32'h1000_0040, 0, 1, 1, 0, NOP,           32'h00);
         add(0, 1, 32'h48, 0, 1, 1, 32'h1000_0044, 0, 1, 1, 1, 32'h1000_0040, 32'h40);
         add(0, 1, 32'h4C, 0, 1, 1, 32'h1000_0048, 0, 1, 1, 1, 32'h1000_0040, 32'h40);
         add(0, 1, 32'h50, 0, 1, 1, 32'h1000_004C, 0, 0, 0, 1, 32'h1000_0040, 32'h40);
         add(0, 1, 32'h50, 0, 1, 0, 32'h0,         0, 0, 0, 1, 32'h1000_0040, 32'h40);
         add(0, 1, 32'h50, 0, 1, 0, 32'h0,         0, 0, 0, 1, 32'h1000_0040, 32'h40);
         add(0, 1, 32'h50, 0, 1, 0, 32'h0,         1, 0, 0, 1, 32'h1000_0040, 32'h40);
         add(0, 1, 32'h50, 0, 1, 0, 32'h0,         1, 1, 1, 1, 32'h1000_0044, 32'h44);
         add(0, 1, 32'h54, 1, 1, 1, 32'hBADB_AD00, 0, 0, 0, 1, 32'h1000_0048, 32'h48);
         add(0, 1, 32'h80, 0, 1, 0, 32'h0,         1, 1, 1, 0, NOP,           32'h00);
         add(0, 1, 32'h84, 0, 0, 1, 32'h1000_0080, 1, 1, 0, 0, NOP,           32'h00);
         add(0, 1, 32'h84, 0, 0, 0, 32'h0,         1, 1, 0, 1, 32'h1000_0080, 32'h80);
         add(0, 1, 32'h84, 0, 0, 0, 32'h0,         1, 1, 0, 0, NOP,           32'h00);
      end else begin
         add(0, 1, 32'h08, 0, 1, 0, 32'h0,         1, 1, 1, 0, NOP,           32'h00);
         add(0, 1, 32'h0C, 0, 0, 1, 32'h0050_0093, 1, 1, 0, 1, 32'h0050_0093, 32'h08);
         add(0, 1, 32'h0C, 0, 0, 0, 32'h0,         1, 1, 0, 0, NOP,           32'h00);
         add(0, 1, 32'h0C, 0, 1, 0, 32'h0,         1, 1, 1, 0, NOP,           32'h00);
         add(0, 1, 32'h10, 0, 0, 1, 32'h1111_1111, 0, 1, 0, 1, 32'h1111_1111, 32'h0C);
         add(0, 1, 32'h10, 0, 0, 0, 32'h0,         1, 1, 0, 1, 32'h1111_1111, 32'h0C);
         add(0, 1, 32'h10, 0, 0, 0, 32'h0,         1, 1, 0, 0, NOP,           32'h00);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].pv, vecs[i].pa, vecs[i].fl, vecs[i].gnt,
               vecs[i].rv, vecs[i].rd, vecs[i].rdy);
         @(negedge clk);
         chk($sformatf("vec%0d imem_req", i),    {31'b0, imem_req},    {31'b0, vecs[i].e_req});
         chk($sformatf("vec%0d pc_adv", i),      {31'b0, pc_adv},      {31'b0, vecs[i].e_adv});
         chk($sformatf("vec%0d imem_addr", i),   imem_addr,            vecs[i].pa);
         chk($sformatf("vec%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_val});
         chk($sformatf("vec%0d instr", i),       instr,                vecs[i].e_ins);
         chk($sformatf("vec%0d instr_pc", i),    instr_pc,             vecs[i].e_pc);
         @(posedge clk); #1;
      end

      // ---------------- randomized phase ----------------
      mq.delete(); m_out = 0; m_keep = 0; m_pc = '0;
      pc = 32'h0; pend = 0; lat = 0; pend_addr = '0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         rst         = (cyc == 0) || ($urandom_range(0, 299) == 0);
         flush       = !rst && ($urandom_range(0, 11) == 0);
         pc_valid    = ($urandom_range(0, 7) != 0);
         imem_gnt    = ($urandom_range(0, 3) != 0);
         instr_ready = (cyc % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         pc_addr     = pc;
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (rst) pend = 0;
         if (pend) begin
            lat--;
            if (lat == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = memfn(pend_addr);
               pend        = 0;
            end
         end
         @(negedge clk);
         model_eval();
         chk($sformatf("rnd%0d imem_req", cyc),    {31'b0, imem_req},    {31'b0, e_req});
         chk($sformatf("rnd%0d pc_adv", cyc),      {31'b0, pc_adv},      {31'b0, e_adv});
         chk($sformatf("rnd%0d imem_addr", cyc),   imem_addr,            pc_addr);
         chk($sformatf("rnd%0d instr_valid", cyc), {31'b0, instr_valid}, {31'b0, e_val});
         chk($sformatf("rnd%0d instr", cyc),       instr,                e_ins);
         chk($sformatf("rnd%0d instr_pc", cyc),    instr_pc,             e_pc);
         model_update();
         if (e_adv) begin
            pend      = 1;
            lat       = $urandom_range(1, 3);
            pend_addr = pc_addr;
         end
         if (flush)      pc = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
         else if (e_adv) pc = pc + 32'd4;
         @(posedge clk); #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
